// File: rtl/ai_scan_if.sv
// Request/result bundle between the board logic and the ai_scan move selector.
// The master drives the board and the handshake inputs. The slave returns the chosen cell.
interface ai_scan_if #(
  parameter int N = 3
);
  localparam int CW = $clog2(N * N);

  logic [2*N*N-1:0] board_state;
  logic             move_req;
  logic             move_ack;
  logic             busy;
  logic             move_valid;
  logic [CW-1:0]    move_loc;
  logic             move_none;

  modport master (
    output board_state, move_req, move_ack,
    input  busy, move_valid, move_loc, move_none
  );

  modport slave (
    input  board_state, move_req, move_ack,
    output busy, move_valid, move_loc, move_none
  );
endinterface

// File: rtl/ai_scan.sv
// Sequential N x N move selector. It scans for a win, then a block, then the centre, then the
// first blank cell. One line or one cell is examined per cycle, against a snapshot of the board.
module ai_scan #(
  parameter int         N       = 3,
  parameter logic [1:0] AI_MARK = 2'b10
) (
  input logic      clk,
  input logic      reset,
  ai_scan_if.slave bus
);
  localparam int CELLS = N * N;
  localparam int LINES = 2 * N + 2;
  localparam int CW    = $clog2(CELLS);
  localparam int LW    = $clog2(LINES);
  localparam int KW    = $clog2(N + 1);
  localparam logic [1:0]    OPP_MARK    = (AI_MARK == 2'b10) ? 2'b01 : 2'b10;
  localparam logic [LW-1:0] LAST_LINE   = LW'(LINES - 1);
  localparam logic [CW-1:0] LAST_CELL   = CW'(CELLS - 1);
  localparam logic [CW-1:0] CENTER_CELL = CW'((CELLS - 1) / 2);
  localparam logic [KW-1:0] HIT_COUNT   = KW'(N - 1);
  localparam bit            HAS_CENTER  = (N % 2) == 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WIN    = 3'd1,
    S_BLOCK  = 3'd2,
    S_CENTER = 3'd3,
    S_FILL   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t              state_r, state_next_s;
  logic [2*CELLS-1:0]  snap_r;
  logic [LW-1:0]       line_r, line_next_s;
  logic [CW-1:0]       cell_r, cell_next_s;
  logic [CW-1:0]       loc_r, loc_next_s;
  logic                none_r, none_next_s;
  logic                busy_r, valid_r;
  logic                snap_load_s;
  logic [1:0]          target_s;
  logic [KW-1:0]       match_cnt_s, blank_cnt_s;
  logic [CW-1:0]       blank_idx_s;
  logic                line_hit_s, cell_blank_s, center_hit_s;

  // Lines are rows, then columns, then the main diagonal and the anti-diagonal.
  function automatic logic [CW-1:0] line_cell(input logic [LW-1:0] ln, input int pos);
    int k;
    int idx;
    k = int'(ln);
    if (k < N) idx = k * N + pos;
    else if (k < 2 * N) idx = pos * N + (k - N);
    else if (k == 2 * N) idx = pos * N + pos;
    else idx = pos * N + (N - 1 - pos);
    return CW'(idx);
  endfunction

  function automatic logic [1:0] cell_at(input logic [2*CELLS-1:0] snap, input logic [CW-1:0] idx);
    return snap[2*int'(idx) +: 2];
  endfunction

  // Evaluate the current line against the mark being hunted in this phase.
  always_comb begin
    match_cnt_s = '0;
    blank_cnt_s = '0;
    blank_idx_s = '0;
    target_s    = (state_r == S_BLOCK) ? OPP_MARK : AI_MARK;
    for (int p = 0; p < N; p++) begin
      if (cell_at(snap_r, line_cell(line_r, p)) == target_s) begin
        match_cnt_s = match_cnt_s + KW'(1);
      end else if (cell_at(snap_r, line_cell(line_r, p)) == 2'b00) begin
        blank_cnt_s = blank_cnt_s + KW'(1);
        blank_idx_s = line_cell(line_r, p);
      end else begin
        blank_cnt_s = blank_cnt_s;
      end
    end
    line_hit_s   = (match_cnt_s == HIT_COUNT) && (blank_cnt_s == KW'(1));
    cell_blank_s = (cell_at(snap_r, cell_r) == 2'b00);
    center_hit_s = HAS_CENTER && (cell_at(snap_r, CENTER_CELL) == 2'b00);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= S_IDLE;
    else state_r <= state_next_s;
  end

  // Next-state selection.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE:   if (bus.move_req) state_next_s = S_WIN; else state_next_s = S_IDLE;
      S_WIN:    if (line_hit_s) state_next_s = S_DONE;
                else if (line_r == LAST_LINE) state_next_s = S_BLOCK;
                else state_next_s = S_WIN;
      S_BLOCK:  if (line_hit_s) state_next_s = S_DONE;
                else if (line_r == LAST_LINE) state_next_s = S_CENTER;
                else state_next_s = S_BLOCK;
      S_CENTER: if (center_hit_s) state_next_s = S_DONE; else state_next_s = S_FILL;
      S_FILL:   if (cell_blank_s || (cell_r == LAST_CELL)) state_next_s = S_DONE;
                else state_next_s = S_FILL;
      S_DONE:   if (bus.move_ack) state_next_s = S_IDLE; else state_next_s = S_DONE;
      default:  state_next_s = S_IDLE;
    endcase
  end

  // Counter, result and snapshot updates for each state.
  always_comb begin
    snap_load_s = 1'b0;
    line_next_s = line_r;
    cell_next_s = cell_r;
    loc_next_s  = loc_r;
    none_next_s = none_r;
    case (state_r)
      S_IDLE: begin
        if (bus.move_req) begin
          snap_load_s = 1'b1;
          line_next_s = '0;
          cell_next_s = '0;
          loc_next_s  = '0;
          none_next_s = 1'b0;
        end else begin
          snap_load_s = 1'b0;
        end
      end
      S_WIN, S_BLOCK: begin
        if (line_hit_s) loc_next_s = blank_idx_s;
        else if (line_r == LAST_LINE) line_next_s = '0;
        else line_next_s = line_r + LW'(1);
      end
      S_CENTER: begin
        if (center_hit_s) loc_next_s = CENTER_CELL;
        else cell_next_s = '0;
      end
      S_FILL: begin
        if (cell_blank_s) loc_next_s = cell_r;
        else if (cell_r == LAST_CELL) none_next_s = 1'b1;
        else cell_next_s = cell_r + CW'(1);
      end
      S_DONE: begin
        if (bus.move_ack) none_next_s = 1'b0;
        else none_next_s = none_r;
      end
      default: begin
        line_next_s = '0;
        cell_next_s = '0;
      end
    endcase
  end

  // Datapath and output registers; busy/valid are registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_r  <= '0;
      line_r  <= '0;
      cell_r  <= '0;
      loc_r   <= '0;
      none_r  <= 1'b0;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      if (snap_load_s) snap_r <= bus.board_state;
      line_r  <= line_next_s;
      cell_r  <= cell_next_s;
      loc_r   <= loc_next_s;
      none_r  <= none_next_s;
      busy_r  <= (state_next_s != S_IDLE);
      valid_r <= (state_next_s == S_DONE);
    end
  end

  assign bus.busy       = busy_r;
  assign bus.move_valid = valid_r;
  assign bus.move_loc   = loc_r;
  assign bus.move_none  = none_r;
endmodule

// File: tb/tb_ai_scan.sv
// Directed bench for ai_scan. It covers a 3x3 board with the O mark, a 4x4 board, and a 3x3 board with the X mark.
module tb_ai_scan;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ai_scan_if #(.N(3)) b3 ();
  ai_scan_if #(.N(4)) b4 ();
  ai_scan_if #(.N(3)) bx ();

  ai_scan #(.N(3), .AI_MARK(2'b10)) u3 (.clk(clk), .reset(reset), .bus(b3));
  ai_scan #(.N(4), .AI_MARK(2'b10)) u4 (.clk(clk), .reset(reset), .bus(b4));
  ai_scan #(.N(3), .AI_MARK(2'b01)) ux (.clk(clk), .reset(reset), .bus(bx));

  // '.' blank, 'X', 'O', '#' occupied by neither mark; character i is cell i.
  function automatic logic [17:0] mk3(input string s);
    logic [17:0] r;
    r = 18'd0;
    for (int i = 0; i < 9; i++) begin
      case (s[i])
        "X":     r[2*i +: 2] = 2'b01;
        "O":     r[2*i +: 2] = 2'b10;
        "#":     r[2*i +: 2] = 2'b11;
        default: r[2*i +: 2] = 2'b00;
      endcase
    end
    return r;
  endfunction

  task automatic run3(input logic [17:0] board, output int lat, output logic busy1);
    b3.board_state = board;
    b3.move_req = 1'b1;
    @(posedge clk); #1;
    b3.move_req = 1'b0;
    busy1 = b3.busy;
    lat = 1;
    while (b3.move_valid !== 1'b1 && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic ack3();
    b3.move_ack = 1'b1;
    @(posedge clk); #1;
    b3.move_ack = 1'b0;
  endtask

  task automatic test_reset();
    if (b3.busy !== 1'b0 || b3.move_valid !== 1'b0) begin n_fail++; $display("FAIL reset_flags busy=%b valid=%b want 0 0", b3.busy, b3.move_valid); end
    n_cmp++;
    if (b3.move_loc !== 4'd0 || b3.move_none !== 1'b0) begin n_fail++; $display("FAIL reset_result loc=%0d none=%b want 0 0", b3.move_loc, b3.move_none); end
    n_cmp++;
    if (b4.busy !== 1'b0 || bx.busy !== 1'b0) begin n_fail++; $display("FAIL reset_other busy4=%b busyx=%b want 0 0", b4.busy, bx.busy); end
    n_cmp++;
  endtask

  task automatic test_centre_hold();
    int lat; logic b1;
    run3(mk3("........."), lat, b1);
    n_cmp++; if (b1 !== 1'b1) begin n_fail++; $display("FAIL centre_busy got %b want 1", b1); end
    n_cmp++; if (lat !== 18) begin n_fail++; $display("FAIL centre_latency got %0d want 18", lat); end
    n_cmp++; if (b3.move_loc !== 4'd4 || b3.move_none !== 1'b0) begin n_fail++; $display("FAIL centre_result loc=%0d none=%b want 4 0", b3.move_loc, b3.move_none); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (b3.move_valid !== 1'b1 || b3.move_loc !== 4'd4) begin n_fail++; $display("FAIL hold_%0d valid=%b loc=%0d want 1 4", i, b3.move_valid, b3.move_loc); end
    end
    ack3();
    n_cmp++; if (b3.move_valid !== 1'b0 || b3.busy !== 1'b0) begin n_fail++; $display("FAIL centre_ack valid=%b busy=%b want 0 0", b3.move_valid, b3.busy); end
  endtask

  task automatic test_win_diag();
    int lat; logic b1;
    run3(mk3("OX.XO...."), lat, b1);
    n_cmp++; if (lat !== 8) begin n_fail++; $display("FAIL win_latency got %0d want 8", lat); end
    n_cmp++; if (b3.move_loc !== 4'd8) begin n_fail++; $display("FAIL win_loc got %0d want 8", b3.move_loc); end
    ack3();
  endtask

  task automatic test_block_row();
    int lat; logic b1;
    run3(mk3("XX..O...."), lat, b1);
    n_cmp++; if (lat !== 10) begin n_fail++; $display("FAIL block_latency got %0d want 10", lat); end
    n_cmp++; if (b3.move_loc !== 4'd2) begin n_fail++; $display("FAIL block_loc got %0d want 2", b3.move_loc); end
    ack3();
  endtask

  task automatic test_occupied_cells();
    int lat; logic b1;
    run3(mk3("OO#O....."), lat, b1);
    n_cmp++; if (lat !== 5 || b3.move_loc !== 4'd6) begin n_fail++; $display("FAIL occ_col lat=%0d loc=%0d want 5 6", lat, b3.move_loc); end
    ack3();
    run3(mk3("#...#...."), lat, b1);
    n_cmp++; if (lat !== 20 || b3.move_loc !== 4'd1 || b3.move_none !== 1'b0) begin n_fail++; $display("FAIL occ_fill lat=%0d loc=%0d none=%b want 20 1 0", lat, b3.move_loc, b3.move_none); end
    ack3();
  endtask

  task automatic test_full_board();
    int lat; logic b1;
    run3(mk3("XOXXOOOXX"), lat, b1);
    n_cmp++; if (lat !== 27) begin n_fail++; $display("FAIL full_latency got %0d want 27", lat); end
    n_cmp++; if (b3.move_none !== 1'b1) begin n_fail++; $display("FAIL full_none got %b want 1", b3.move_none); end
    ack3();
  endtask

  task automatic test_reset_mid_win();
    int lat; logic b1;
    b3.board_state = mk3(".........");
    b3.move_req = 1'b1;
    @(posedge clk); #1;
    b3.move_req = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    n_cmp++; if (b3.busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre busy=%b want 1", b3.busy); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++;
    if (b3.busy !== 1'b0 || b3.move_valid !== 1'b0 || b3.move_loc !== 4'd0 || b3.move_none !== 1'b0) begin
      n_fail++; $display("FAIL abort_outputs busy=%b valid=%b loc=%0d none=%b want all 0", b3.busy, b3.move_valid, b3.move_loc, b3.move_none);
    end
    run3(mk3("XX..O...."), lat, b1);
    n_cmp++; if (lat !== 10 || b3.move_loc !== 4'd2) begin n_fail++; $display("FAIL abort_rerun lat=%0d loc=%0d want 10 2", lat, b3.move_loc); end
    ack3();
  endtask

  task automatic test_busy_ignore();
    int lat;
    b3.board_state = mk3(".........");
    b3.move_req = 1'b1;
    @(posedge clk); #1;
    b3.move_req = 1'b0;
    lat = 1;
    repeat (3) begin @(posedge clk); #1; lat++; end
    b3.board_state = mk3("OO.......");
    b3.move_req = 1'b1;
    @(posedge clk); #1; lat++;
    b3.move_req = 1'b0;
    while (b3.move_valid !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat !== 18) begin n_fail++; $display("FAIL ignore_latency got %0d want 18", lat); end
    n_cmp++; if (b3.move_loc !== 4'd4) begin n_fail++; $display("FAIL ignore_loc got %0d want 4", b3.move_loc); end
    b3.move_req = 1'b1;
    b3.move_ack = 1'b1;
    @(posedge clk); #1;
    b3.move_req = 1'b0;
    b3.move_ack = 1'b0;
    n_cmp++; if (b3.move_valid !== 1'b0 || b3.busy !== 1'b0) begin n_fail++; $display("FAIL reqack_idle valid=%b busy=%b want 0 0", b3.move_valid, b3.busy); end
    @(posedge clk); #1;
    n_cmp++; if (b3.busy !== 1'b0) begin n_fail++; $display("FAIL reqack_dropped busy=%b want 0", b3.busy); end
  endtask

  task automatic test_n4_and_xmark();
    int lat;
    b4.move_req = 1'b1;
    bx.board_state = mk3("XX.......");
    bx.move_req = 1'b1;
    @(posedge clk); #1;
    b4.move_req = 1'b0;
    bx.move_req = 1'b0;
    lat = 1;
    while (bx.move_valid !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat !== 2 || bx.move_loc !== 4'd2) begin n_fail++; $display("FAIL xmark_win lat=%0d loc=%0d want 2 2", lat, bx.move_loc); end
    while (b4.move_valid !== 1'b1 && lat < 80) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat !== 23) begin n_fail++; $display("FAIL n4_latency got %0d want 23", lat); end
    n_cmp++; if (b4.move_loc !== 4'd0 || b4.move_none !== 1'b0) begin n_fail++; $display("FAIL n4_result loc=%0d none=%b want 0 0", b4.move_loc, b4.move_none); end
    b4.move_ack = 1'b1;
    bx.move_ack = 1'b1;
    @(posedge clk); #1;
    b4.move_ack = 1'b0;
    bx.move_ack = 1'b0;
    n_cmp++; if (b4.busy !== 1'b0 || bx.move_valid !== 1'b0) begin n_fail++; $display("FAIL n4x_ack busy4=%b validx=%b want 0 0", b4.busy, bx.move_valid); end
  endtask

  initial begin
    b3.board_state = '0; b3.move_req = 1'b0; b3.move_ack = 1'b0;
    b4.board_state = '0; b4.move_req = 1'b0; b4.move_ack = 1'b0;
    bx.board_state = '0; bx.move_req = 1'b0; bx.move_ack = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_centre_hold();
    test_win_diag();
    test_block_row();
    test_occupied_cells();
    test_full_board();
    test_reset_mid_win();
    test_busy_ignore();
    test_n4_and_xmark();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
